// File: rtl/dot_product_accumulator_if.sv
// Handshake bundle between the multiplier-side feeder, the dot-product accumulator and its consumer.
// master = feeder/consumer side, slave = accumulator side.
interface dot_product_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              overflow;
  logic [7:0]        count;

  modport master (
    output clear, in_valid, product, out_ready,
    input  in_ready, out_valid, result, overflow, count
  );

  modport slave (
    input  clear, in_valid, product, out_ready,
    output in_ready, out_valid, result, overflow, count
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums LEN unsigned products into one dot product and presents it over valid/ready.
// Optional SATURATE_EN: clamp the running sum at all-ones on carry out instead of wrapping.
module dot_product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN    = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  dot_product_accumulator_if.slave bus
);
  // state | meaning
  // ACCUM | accepting products, in_ready=1, out_valid=0
  // HOLD  | result presented and held until out_ready, in_ready=0
  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] LEN_B = 8'(LEN);
`ifdef SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
`endif

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   sum;
  logic [7:0]       remain;
  logic [7:0]       count_q;
  logic [ACC_W-1:0] result_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             overflow_q;
  logic             carry;
  logic             accept;
  logic             last_beat;

  always_comb begin
    sum    = {1'b0, acc} + (ACC_W+1)'(bus.product);
    carry  = sum[ACC_W];
`ifdef SATURATE_EN
    // once clamped, any further non-zero add carries again, so the sum stays pinned
    acc_next = carry ? ACC_MAX : sum[ACC_W-1:0];
`else
    acc_next = sum[ACC_W-1:0];
`endif
    accept    = bus.in_valid && in_ready_q;
    last_beat = (remain == 8'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      acc         <= '0;
      remain      <= LEN_B;
      count_q     <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (bus.clear) begin
      state       <= ACCUM;
      acc         <= '0;
      remain      <= LEN_B;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc     <= acc_next;
            count_q <= count_q + 8'd1;
            remain  <= remain - 8'd1;
            if (carry) begin
              overflow_q <= 1'b1;
            end
            if (last_beat) begin
              result_q    <= acc_next;
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= ACCUM;
            acc         <= '0;
            remain      <= LEN_B;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: four instances (LEN 1/2/3/4) checked against a sum-of-products model.
// Build with +define+SATURATE_EN to check the clamping variant.
module tb_dot_product_accumulator;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dot_product_accumulator_if #(.PROD_W(16), .ACC_W(24)) b1 ();
  dot_product_accumulator_if #(.PROD_W(16), .ACC_W(24)) b2 ();
  dot_product_accumulator_if #(.PROD_W(16), .ACC_W(24)) b3 ();
  dot_product_accumulator_if #(.PROD_W(16), .ACC_W(17)) b4 ();

  dot_product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  dot_product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  dot_product_accumulator #(.PROD_W(16), .ACC_W(24), .LEN(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  dot_product_accumulator #(.PROD_W(16), .ACC_W(17), .LEN(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  // Expected result for a true (unbounded) sum s in a w-bit accumulator.
  function automatic longint exp_result(longint s, int w);
    longint lim;
    lim = longint'(1) << w;
`ifdef SATURATE_EN
    return (s >= lim) ? lim - 1 : s;
`else
    return s % lim;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    b1.clear = 0; b1.in_valid = 0; b1.product = '0; b1.out_ready = 0;
    b2.clear = 0; b2.in_valid = 0; b2.product = '0; b2.out_ready = 0;
    b3.clear = 0; b3.in_valid = 0; b3.product = '0; b3.out_ready = 0;
    b4.clear = 0; b4.in_valid = 0; b4.product = '0; b4.out_ready = 0;
  endtask

  task automatic test_reset();
    init_inputs();
    #2 rst_n = 1'b0;
    #10;
    checks++;
    if (b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake in_ready=%b out_valid=%b required 1 0", b2.in_ready, b2.out_valid);
    end
    checks++;
    if (b2.result !== 24'd0 || b2.overflow !== 1'b0 || b2.count !== 8'd0) begin
      errors++;
      $display("FAIL reset_values result=%0d overflow=%b count=%0d required 0 0 0", b2.result, b2.overflow, b2.count);
    end
    #10 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [23:0] e;
    e = 24'(exp_result(1070 + 7093, 24));
    b2.out_ready = 1; b2.in_valid = 1; b2.product = 16'd1070;
    step();
    checks++;
    if (b2.count !== 8'd1 || b2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_first_accept count=%0d out_valid=%b required 1 0", b2.count, b2.out_valid);
    end
    b2.product = 16'd7093;
    step();
    b2.in_valid = 0;
    checks++;
    if (b2.out_valid !== 1'b1 || b2.result !== e || b2.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_result out_valid=%b result=%0d in_ready=%b required 1 %0d 0", b2.out_valid, b2.result, b2.in_ready, e);
    end
    checks++;
    if (b2.overflow !== 1'b0 || b2.count !== 8'd2) begin
      errors++;
      $display("FAIL basic_flags overflow=%b count=%0d required 0 2", b2.overflow, b2.count);
    end
    step();
    checks++;
    if (b2.out_valid !== 1'b0 || b2.count !== 8'd0 || b2.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake out_valid=%b count=%0d in_ready=%b required 0 0 1", b2.out_valid, b2.count, b2.in_ready);
    end
    b2.out_ready = 0;
  endtask

  task automatic test_stall();
    b2.in_valid = 1; b2.product = 16'd1070;
    step();
    b2.product = 16'd7093;
    step();
    for (int i = 0; i < 5; i++) begin
      b2.product = 16'($urandom);
      b2.in_valid = 1;
      step();
      checks++;
      if (b2.result !== 24'd8163 || b2.in_ready !== 1'b0 || b2.out_valid !== 1'b1 || b2.count !== 8'd2) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d result=%0d in_ready=%b out_valid=%b count=%0d required 8163 0 1 2",
                 i, b2.result, b2.in_ready, b2.out_valid, b2.count);
      end
    end
    b2.in_valid = 0; b2.out_ready = 1;
    step();
    checks++;
    if (b2.count !== 8'd0 || b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release count=%0d in_ready=%b out_valid=%b required 0 1 0", b2.count, b2.in_ready, b2.out_valid);
    end
    b2.out_ready = 0;
  endtask

  task automatic test_overflow();
    logic [16:0] e;
    e = 17'(exp_result(4 * 65535, 17));
    b4.in_valid = 1; b4.product = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 1) begin
        checks++;
        if (b4.overflow !== 1'b0) begin
          errors++;
          $display("FAIL overflow_early overflow=%b required 0 after two accepts", b4.overflow);
        end
      end
    end
    b4.in_valid = 0;
    checks++;
    if (b4.out_valid !== 1'b1 || b4.result !== e || b4.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_result out_valid=%b result=%0d overflow=%b required 1 %0d 1", b4.out_valid, b4.result, b4.overflow, e);
    end
    b4.out_ready = 1;
    step();
    checks++;
    if (b4.overflow !== 1'b0 || b4.count !== 8'd0) begin
      errors++;
      $display("FAIL overflow_cleared overflow=%b count=%0d required 0 0", b4.overflow, b4.count);
    end
    b4.out_ready = 0;
  endtask

  task automatic test_clear();
    b3.in_valid = 1; b3.product = 16'd100;
    step();
    b3.product = 16'd200;
    step();
    b3.clear = 1; b3.product = 16'd5;
    step();
    b3.clear = 0;
    checks++;
    if (b3.count !== 8'd0 || b3.in_ready !== 1'b1 || b3.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_accum count=%0d in_ready=%b out_valid=%b required 0 1 0", b3.count, b3.in_ready, b3.out_valid);
    end
    b3.product = 16'd1;
    for (int i = 0; i < 3; i++) step();
    b3.in_valid = 0;
    checks++;
    if (b3.out_valid !== 1'b1 || b3.result !== 24'd3) begin
      errors++;
      $display("FAIL clear_restart out_valid=%b result=%0d required 1 3", b3.out_valid, b3.result);
    end
    b3.clear = 1;
    step();
    b3.clear = 0;
    checks++;
    if (b3.out_valid !== 1'b0 || b3.in_ready !== 1'b1 || b3.result !== 24'd3 || b3.count !== 8'd0) begin
      errors++;
      $display("FAIL clear_in_hold out_valid=%b in_ready=%b result=%0d count=%0d required 0 1 3 0",
               b3.out_valid, b3.in_ready, b3.result, b3.count);
    end
  endtask

  task automatic test_async_reset();
    b2.in_valid = 1; b2.product = 16'd1070;
    step();
    b2.in_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (b2.count !== 8'd0 || b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0 || b2.result !== 24'd0) begin
      errors++;
      $display("FAIL async_reset count=%0d in_ready=%b out_valid=%b result=%0d required 0 1 0 0",
               b2.count, b2.in_ready, b2.out_valid, b2.result);
    end
    #2 rst_n = 1'b1;
    step();
    b2.in_valid = 1; b2.product = 16'd1070;
    step();
    b2.product = 16'd7093;
    step();
    b2.in_valid = 0;
    checks++;
    if (b2.out_valid !== 1'b1 || b2.result !== 24'd8163) begin
      errors++;
      $display("FAIL async_rerun out_valid=%b result=%0d required 1 8163", b2.out_valid, b2.result);
    end
    b2.out_ready = 1;
    step();
    b2.out_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    int idx, got, last_acc, prev_ov;
    logic acc_now;
    vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30;
    idx = 0; got = 0; last_acc = -1; prev_ov = 0;
    b1.product = vals[0]; b1.in_valid = 1; b1.out_ready = 1;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      acc_now = b1.in_valid && b1.in_ready;
      step();
      if (acc_now) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 2) begin
            errors++;
            $display("FAIL b2b_accept_gap gap=%0d required 2", cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
        if (idx < 3) b1.product = vals[idx];
        else b1.in_valid = 0;
      end
      if (b1.out_valid === 1'b1) begin
        checks++;
        if (b1.result !== 24'(vals[got]) || prev_ov != 0) begin
          errors++;
          $display("FAIL b2b_result index=%0d result=%0d prev_out_valid=%0d required %0d 0", got, b1.result, prev_ov, vals[got]);
        end
        got++;
        prev_ov = 1;
      end else begin
        prev_ov = 0;
      end
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL b2b_timeout results=%0d required 3", got);
    end
    b1.in_valid = 0; b1.out_ready = 0;
    step();
  endtask

  task automatic test_random();
    longint msum;
    int mcount, done;
    logic hs_in, hs_out;
    logic [16:0] e;
    msum = 0; mcount = 0; done = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      b4.in_valid  = ($urandom_range(0, 3) != 0);
      b4.product   = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(60000, 65535)) : 16'($urandom_range(0, 65535));
      b4.out_ready = ($urandom_range(0, 2) != 0);
      hs_in  = b4.in_valid && (mcount != 4);
      hs_out = (mcount == 4) && b4.out_ready;
      if (hs_in) begin
        msum += longint'(b4.product);
        mcount++;
      end
      step();
      if (hs_out) begin
        msum = 0;
        mcount = 0;
        done++;
      end
      checks++;
      if (b4.count !== 8'(mcount) || b4.in_ready !== (mcount != 4) || b4.out_valid !== (mcount == 4)) begin
        errors++;
        $display("FAIL random_ctrl cycle=%0d count=%0d in_ready=%b out_valid=%b required %0d %b %b",
                 cyc, b4.count, b4.in_ready, b4.out_valid, mcount, (mcount != 4), (mcount == 4));
      end
      checks++;
      if (b4.overflow !== (msum >= 131072)) begin
        errors++;
        $display("FAIL random_overflow cycle=%0d overflow=%b required %b", cyc, b4.overflow, (msum >= 131072));
      end
      if (mcount == 4) begin
        e = 17'(exp_result(msum, 17));
        checks++;
        if (b4.result !== e) begin
          errors++;
          $display("FAIL random_result cycle=%0d result=%0d required %0d", cyc, b4.result, e);
        end
      end
    end
    checks++;
    if (done < 10) begin
      errors++;
      $display("FAIL random_progress completed=%0d required at least 10", done);
    end
    b4.in_valid = 0; b4.out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_clear();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
